// File: rtl/alu_sched.sv
// alu_sched: round-robin issue of four requesters into one shared 3-stage ALU.
// The requester id rides in the ALU sideband so each result is steered back to its issuer.
module alu_sched #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DATABITS = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic [3:0]                  req_valid,
    output logic [3:0]                  req_ready,
    input  logic [4*WIDTH-1:0]          req_a,
    input  logic [4*WIDTH-1:0]          req_b,
    input  logic [7:0]                  req_op,
    input  logic [4*(DATABITS-2)-1:0]   req_tag,
    output logic [WIDTH-1:0]            alu_a,
    output logic [WIDTH-1:0]            alu_b,
    output logic [1:0]                  alu_op,
    output logic [DATABITS-1:0]         alu_databits,
    input  logic [WIDTH-1:0]            alu_res,
    input  logic [1:0]                  alu_out_op,
    input  logic [DATABITS-1:0]         alu_out_databits,
    output logic [3:0]                  rsp_valid,
    output logic [WIDTH-1:0]            rsp_res,
    output logic [1:0]                  rsp_op,
    output logic [DATABITS-3:0]         rsp_tag,
    output logic                        busy
);

    localparam int unsigned TAGBITS = DATABITS - 2;
    localparam logic [1:0]  OP_NOP  = 2'd0;

    logic [WIDTH-1:0]   a_arr   [4];
    logic [WIDTH-1:0]   b_arr   [4];
    logic [1:0]         op_arr  [4];
    logic [TAGBITS-1:0] tag_arr [4];

    logic [1:0] last;
    logic [3:0] v;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic [1:0] cand;
    logic       found;
    logic       accept;
    logic [1:0] rsp_id;

    for (genvar i = 0; i < 4; i++) begin : g_split
        assign a_arr[i]   = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i]   = req_b[i*WIDTH +: WIDTH];
        assign op_arr[i]  = req_op[2*i +: 2];
        assign tag_arr[i] = req_tag[i*TAGBITS +: TAGBITS];
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant    = 4'b0000;
        grant_id = 2'd0;
        found    = 1'b0;
        cand     = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant_id    = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    assign accept    = found & ~hold & ~reset;
    assign req_ready = accept ? grant : 4'b0000;

    // Issue register plus shadow valid pipeline tracking the ALU stages
    always_ff @(posedge clk) begin
        if (reset) begin
            last         <= 2'd3;
            v            <= 4'b0000;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_NOP;
            alu_databits <= '0;
        end else begin
            v <= {v[2:0], accept};
            if (accept) begin
                last         <= grant_id;
                alu_a        <= a_arr[grant_id];
                alu_b        <= b_arr[grant_id];
                alu_op       <= op_arr[grant_id];
                alu_databits <= {grant_id, tag_arr[grant_id]};
            end else begin
                alu_op       <= OP_NOP;
                alu_databits <= '0;
            end
        end
    end

    assign rsp_id    = alu_out_databits[DATABITS-1 -: 2];
    assign rsp_valid = v[3] ? (4'b0001 << rsp_id) : 4'b0000;
    assign rsp_res   = alu_res;
    assign rsp_op    = alu_out_op;
    assign rsp_tag   = alu_out_databits[TAGBITS-1:0];
    assign busy      = |v;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: alu_sched driving a 3-stage ALU model; a scoreboard queue predicts
// grants and responses from the round-robin rules and a negedge monitor checks them.
module tb_alu_sched;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DATABITS = 7;
    localparam int unsigned TAGBITS  = DATABITS - 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      hold;
    logic [3:0]                req_valid;
    logic [3:0]                req_ready;
    logic [4*WIDTH-1:0]        req_a;
    logic [4*WIDTH-1:0]        req_b;
    logic [7:0]                req_op;
    logic [4*TAGBITS-1:0]      req_tag;
    logic [WIDTH-1:0]          alu_a;
    logic [WIDTH-1:0]          alu_b;
    logic [1:0]                alu_op;
    logic [DATABITS-1:0]       alu_databits;
    logic [WIDTH-1:0]          alu_res;
    logic [1:0]                alu_out_op;
    logic [DATABITS-1:0]       alu_out_databits;
    logic [3:0]                rsp_valid;
    logic [WIDTH-1:0]          rsp_res;
    logic [1:0]                rsp_op;
    logic [TAGBITS-1:0]        rsp_tag;
    logic                      busy;

    alu_sched #(.WIDTH(WIDTH), .DATABITS(DATABITS)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_databits(alu_databits),
        .alu_res(alu_res), .alu_out_op(alu_out_op), .alu_out_databits(alu_out_databits),
        .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] op);
        case (op)
            2'd1:    return a + b;
            2'd2:    return a - b;
            2'd3:    return WIDTH'(a * b);
            default: return '0;
        endcase
    endfunction

    // Three-register ALU model: phase 1, phase 2, output register
    logic [WIDTH-1:0]    p1_res, p2_res;
    logic [1:0]          p1_op, p2_op;
    logic [DATABITS-1:0] p1_db, p2_db;
    always @(posedge clk) begin
        p1_res           <= alu_fn(alu_a, alu_b, alu_op);
        p1_op            <= alu_op;
        p1_db            <= alu_databits;
        p2_res           <= p1_res;
        p2_op            <= p1_op;
        p2_db            <= p1_db;
        alu_res          <= p2_res;
        alu_out_op       <= p2_op;
        alu_out_databits <= p2_db;
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int                 id;
        logic [WIDTH-1:0]   res;
        logic [1:0]         op;
        logic [TAGBITS-1:0] tag;
        int                 due;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   rr_last = 3;

    function automatic logic [3:0] model_grant(input logic [3:0] valid, input int lst);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (lst + k) % 4;
            if (valid[c]) return 4'b0001 << c;
        end
        return 4'b0000;
    endfunction

    // Monitor: busy, responses, grants; then enqueue newly accepted requests
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] eg;
        cyc++;
        chk(busy == (q.size() != 0), "busy", 64'(busy), 64'(q.size() != 0));
        if (rsp_valid != 4'b0000) begin
            if (q.size() == 0 || q[0].due != cyc) begin
                chk(1'b0, "rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk(rsp_valid == (4'b0001 << e.id), "rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
                chk(rsp_res == e.res, "rsp_res", 64'(rsp_res), 64'(e.res));
                chk(rsp_op == e.op, "rsp_op", 64'(rsp_op), 64'(e.op));
                chk(rsp_tag == e.tag, "rsp_tag", 64'(rsp_tag), 64'(e.tag));
            end
        end else if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk(1'b0, "rsp_missing", 64'(rsp_valid), 64'(4'b0001 << e.id));
        end
        eg = (hold || reset) ? 4'b0000 : model_grant(req_valid, rr_last);
        chk(req_ready == eg, "req_ready", 64'(req_ready), 64'(eg));
        if (eg != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (eg[i]) begin
                    e.id  = i;
                    e.op  = req_op[2*i +: 2];
                    e.res = alu_fn(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], e.op);
                    e.tag = req_tag[i*TAGBITS +: TAGBITS];
                    e.due = cyc + 4;
                    q.push_back(e);
                    rr_last = i;
                end
            end
        end
        if (reset) begin
            q.delete();
            rr_last = 3;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [1:0] op, input logic [TAGBITS-1:0] tag);
        req_a[i*WIDTH +: WIDTH]       = a;
        req_b[i*WIDTH +: WIDTH]       = b;
        req_op[2*i +: 2]              = op;
        req_tag[i*TAGBITS +: TAGBITS] = tag;
    endtask

    // Lone request with hand-computed expectations; pipeline must be idle on entry
    task automatic directed(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [1:0] op, input logic [TAGBITS-1:0] tag,
                            input logic [WIDTH-1:0] exp_res);
        set_req(id, a, b, op, tag);
        req_valid = 4'b0001 << id;
        @(negedge clk);
        chk(req_ready == (4'b0001 << id), "dir_ready", 64'(req_ready), 64'(4'b0001 << id));
        step();
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        chk(rsp_valid == (4'b0001 << id), "dir_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << id));
        chk(rsp_res == exp_res, "dir_rsp_res", 64'(rsp_res), 64'(exp_res));
        chk(rsp_op == op, "dir_rsp_op", 64'(rsp_op), 64'(op));
        chk(rsp_tag == tag, "dir_rsp_tag", 64'(rsp_tag), 64'(tag));
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        hold      = 1'b0;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_tag   = '0;
        step();
        step();
        @(negedge clk);
        chk(alu_op == 2'd0, "reset_alu_op", 64'(alu_op), 64'(0));
        chk(alu_databits == '0, "reset_alu_databits", 64'(alu_databits), 64'(0));
        chk(alu_a == '0 && alu_b == '0, "reset_alu_ab", {alu_a, alu_b}, 64'(0));
        chk(rsp_valid == 4'b0000, "reset_rsp_valid", 64'(rsp_valid), 64'(0));
        step();
        reset = 1'b0;

        directed(2, 32'd7, 32'd5, 2'd1, 5'd9, 32'd12);
        directed(1, 32'd0, 32'd1, 2'd2, 5'd3, 32'hFFFF_FFFF);
        directed(1, 32'hFFFF_FFFF, 32'd2, 2'd1, 5'd4, 32'd1);
        directed(0, 32'd123, 32'd456, 2'd0, 5'd31, 32'd0);

        // Fairness from a fresh reset: grants 0,1,2,3,0,...
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'd3, 32'(i + 1), 2'd3, 5'(i));
        req_valid = 4'hF;
        repeat (8) step();
        req_valid = 4'h0;
        repeat (6) step();

        // hold with an operation already in flight
        set_req(0, 32'd10, 32'd20, 2'd1, 5'd1);
        req_valid = 4'b0001;
        step();
        set_req(1, 32'd50, 32'd8, 2'd2, 5'd2);
        req_valid = 4'b0010;
        hold      = 1'b1;
        repeat (3) step();
        hold = 1'b0;
        step();
        req_valid = 4'b0000;
        repeat (6) step();

        // Reset right after three back-to-back issues drops all of them
        req_valid = 4'hF;
        repeat (3) step();
        req_valid = 4'h0;
        pulse_reset();
        @(negedge clk);
        chk(busy == 1'b0, "busy_after_reset", 64'(busy), 64'(0));
        step();
        directed(3, 32'd100, 32'd1, 2'd2, 5'd17, 32'd99);

        // Randomized traffic with occasional hold and reset
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                set_req(i, ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255)),
                        ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255)),
                        2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            end
            req_valid = 4'($urandom_range(0, 15));
            hold      = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 79) == 0);
            step();
        end
        req_valid = 4'h0;
        hold      = 1'b0;
        reset     = 1'b0;
        repeat (8) step();
        chk(q.size() == 0, "drain_empty", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
